leaf_out_arbiter: RTL

- Shares a leaf's single BFT egress between NUM_OUT_PORTS user output streams that use the ap_vld/ap_ack handshake.
- Arbitration is round-robin and credit-gated per port.
- Each accepted 32-bit word is formatted into a 49-bit packet, using a per-port routing table written by the controller.
- Sits between the HLS user kernel outputs and the leaf packet-egress logic. It gives ordering, fairness and back-pressure that the flat port concatenation lacks.

---
 rtl/leaf_out_arbiter_if.sv | 40 ++++
 rtl/leaf_out_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/leaf_out_arbiter_if.sv
// Bundle between the user kernel outputs, the routing/credit controller,
// the leaf packet-egress logic and the output arbiter.
interface leaf_out_arbiter_if #(
   parameter int NUM_OUT_PORTS = 2,
   parameter int PAYLOAD_BITS  = 32,
   parameter int PACKET_BITS   = 49,
   parameter int NUM_LEAF_BITS = 3,
   parameter int NUM_PORT_BITS = 4,
   parameter int CREDIT_BITS   = 8
);
   logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
   logic [NUM_OUT_PORTS-1:0]              vld_user;
   logic [NUM_OUT_PORTS-1:0]              ack_user;
   logic                                  cfg_we;
   logic [2:0]                            cfg_port;
   logic                                  cfg_en;
   logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf;
   logic [NUM_PORT_BITS-1:0]              cfg_dest_port;
   logic                                  credit_vld;
   logic [2:0]                            credit_port;
   logic [CREDIT_BITS-1:0]                credit_amt;
   logic [PACKET_BITS-1:0]                pkt_out;
   logic                                  pkt_vld;
   logic                                  pkt_ready;
   logic [NUM_OUT_PORTS-1:0]              credit_zero;

   // Environment side: user kernels, controller and downstream egress.
   modport master (
      output din_user, vld_user, cfg_we, cfg_port, cfg_en, cfg_dest_leaf,
             cfg_dest_port, credit_vld, credit_port, credit_amt, pkt_ready,
      input  ack_user, pkt_out, pkt_vld, credit_zero
   );

   // Arbiter side.
   modport slave (
      input  din_user, vld_user, cfg_we, cfg_port, cfg_en, cfg_dest_leaf,
             cfg_dest_port, credit_vld, credit_port, credit_amt, pkt_ready,
      output ack_user, pkt_out, pkt_vld, credit_zero
   );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Round-robin, credit-gated arbiter that shares one leaf egress between
// several ap_vld/ap_ack user output streams and formats each accepted word
// into a routed packet with a per-port sequence number.
module leaf_out_arbiter #(
   parameter int NUM_OUT_PORTS = 2,
   parameter int PAYLOAD_BITS  = 32,
   parameter int PACKET_BITS   = 49,
   parameter int NUM_LEAF_BITS = 3,
   parameter int NUM_PORT_BITS = 4,
   parameter int NUM_SEQ_BITS  = 7,
   parameter int CREDIT_BITS   = 8,
   parameter int INIT_CREDIT   = 64
) (
   input  logic               clk,
   input  logic               reset,
   leaf_out_arbiter_if.slave  bus
);
   localparam int PTR_W    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam int SEQ_LSB  = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - NUM_SEQ_BITS;
   localparam int PORT_LSB = SEQ_LSB + NUM_SEQ_BITS;
   localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;
   localparam logic [CREDIT_BITS-1:0] CREDIT_MAX  = '1;
   localparam logic [CREDIT_BITS-1:0] CREDIT_INIT = CREDIT_BITS'(INIT_CREDIT);
   localparam logic [PTR_W-1:0]       PTR_INIT    = PTR_W'(NUM_OUT_PORTS - 1);

   logic [NUM_OUT_PORTS-1:0] route_en;
   logic [NUM_LEAF_BITS-1:0] route_leaf [NUM_OUT_PORTS];
   logic [NUM_PORT_BITS-1:0] route_port [NUM_OUT_PORTS];
   logic [NUM_SEQ_BITS-1:0]  seq        [NUM_OUT_PORTS];
   logic [CREDIT_BITS-1:0]   credit     [NUM_OUT_PORTS];
   logic [CREDIT_BITS-1:0]   credit_next[NUM_OUT_PORTS];
   logic [PTR_W-1:0]         ptr;
   logic [PACKET_BITS-1:0]   pkt_q;
   logic                     pkt_vld_q;
   logic [NUM_OUT_PORTS-1:0] credit_zero_q;

   logic                     slot_free;
   logic [NUM_OUT_PORTS-1:0] eligible;
   logic                     gnt_vld;
   logic [PTR_W-1:0]         gnt_idx;
   logic [NUM_OUT_PORTS-1:0] ack;
   logic [PAYLOAD_BITS-1:0]  gnt_word;
   logic [PACKET_BITS-1:0]   pkt_next;

   assign slot_free = !pkt_vld_q || bus.pkt_ready;

   // A port can be served only if it has data, is routed and holds credit.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         eligible[i] = bus.vld_user[i] && route_en[i] && (credit[i] != '0);
      end
   end

   // Round-robin search starting just after the last granted port.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
         if (!gnt_vld && slot_free && eligible[(int'(ptr) + k) % NUM_OUT_PORTS]) begin
            gnt_vld = 1'b1;
            gnt_idx = PTR_W'((int'(ptr) + k) % NUM_OUT_PORTS);
         end
      end
   end

   // One-hot accept toward the granted user stream.
   always_comb begin
      ack = '0;
      if (gnt_vld) ack[gnt_idx] = 1'b1;
   end

   assign gnt_word = bus.din_user[int'(gnt_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];

   // Packet image built from the routing entry as it stands before this edge.
   always_comb begin
      pkt_next = '0;
      pkt_next[PACKET_BITS-1]              = 1'b1;
      pkt_next[LEAF_LSB +: NUM_LEAF_BITS]  = route_leaf[gnt_idx];
      pkt_next[PORT_LSB +: NUM_PORT_BITS]  = route_port[gnt_idx];
      pkt_next[SEQ_LSB +: NUM_SEQ_BITS]    = seq[gnt_idx];
      pkt_next[PAYLOAD_BITS-1:0]           = gnt_word;
   end

   // Net credit per port: return minus grant, saturated after the sum.
   always_comb begin
      logic [CREDIT_BITS:0] sum;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         sum = {1'b0, credit[i]};
         if (bus.credit_vld && bus.credit_port == 3'(i)) sum = sum + {1'b0, bus.credit_amt};
         if (gnt_vld && gnt_idx == PTR_W'(i)) sum = sum - (CREDIT_BITS+1)'(1);
         credit_next[i] = sum[CREDIT_BITS] ? CREDIT_MAX : sum[CREDIT_BITS-1:0];
      end
   end

   // Output slot, sequence numbers and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_q     <= '0;
         pkt_vld_q <= 1'b0;
         ptr       <= PTR_INIT;
         for (int i = 0; i < NUM_OUT_PORTS; i++) seq[i] <= '0;
      end else if (gnt_vld) begin
         pkt_q        <= pkt_next;
         pkt_vld_q    <= 1'b1;
         ptr          <= gnt_idx;
         seq[gnt_idx] <= seq[gnt_idx] + NUM_SEQ_BITS'(1);
      end else if (slot_free) begin
         pkt_vld_q <= 1'b0;
      end
   end

   // Routing table; out-of-range port indices match no entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         route_en <= '0;
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            route_leaf[i] <= '0;
            route_port[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (bus.cfg_we && bus.cfg_port == 3'(i)) begin
               route_en[i]   <= bus.cfg_en;
               route_leaf[i] <= bus.cfg_dest_leaf;
               route_port[i] <= bus.cfg_dest_port;
            end
         end
      end
   end

   // Credit counters and their registered zero flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         credit_zero_q <= '0;
         for (int i = 0; i < NUM_OUT_PORTS; i++) credit[i] <= CREDIT_INIT;
      end else begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit[i]        <= credit_next[i];
            credit_zero_q[i] <= (credit_next[i] == '0);
         end
      end
   end

   assign bus.ack_user    = ack;
   assign bus.pkt_out     = pkt_q;
   assign bus.pkt_vld     = pkt_vld_q;
   assign bus.credit_zero = credit_zero_q;
endmodule
